// File: rtl/stopwatch_bcd_n.sv
// stopwatch_bcd_n: parametrised N-digit BCD stopwatch/timer core.
//
// Counts DIGITS decimal digits, one step every DVSR running clock cycles, up or down. It supports:
//   - a BCD preset load (nibbles above 9 are clamped to 9)
//   - wrap or saturate at the range limit
//   - a lap freeze of the display value
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); digit 0 is least significant
//   DVSR     clk cycles per least-significant-digit step (>= 2)
//   WRAP     1 = wrap at the range limit, 0 = saturate and stop
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   go        1 = run, 0 = pause (prescaler and digits hold)
//   clr       synchronous clear of count, prescaler, lap and flags
//   dir       0 = count up, 1 = count down
//   load      one-cycle pulse, loads load_val into the count
//   load_val  BCD preset, nibble k is digit k
//   lap       one-cycle pulse, toggles the display freeze
//   count     live BCD count
//   disp      lap value while frozen, otherwise count
//   frozen    lap freeze active
//   tick      high in the cycle a count step is applied
//   ovf       sticky wrap / saturation flag
module stopwatch_bcd_n #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DVSR   = 10000000,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  clr,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  frozen,
  output logic                  tick,
  output logic                  ovf
);

  localparam int unsigned PW = $clog2(DVSR);
  localparam int unsigned W  = 4 * DIGITS;

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  lap_q, lap_d;
  logic          frozen_q, frozen_d;
  logic          ovf_q, ovf_d;

  logic          last;
  logic          stopped;
  logic          step;

  logic [W-1:0]  up_val, dn_val, stepped, sat_val, lim9, load_clamped;
  logic          all9, all0, wrap_hit, up_c, dn_c;
  logic [3:0]    dig;

  // Saturation mode halts everything once the limit has been flagged.
  assign stopped = !WRAP && ovf_q;
  assign last    = (presc_q == PW'(DVSR - 1));
  assign step    = go && !stopped && last;

  // Ripple-carry / ripple-borrow BCD increment and decrement of the whole count.
  always_comb begin
    up_val       = count_q;
    dn_val       = count_q;
    lim9         = '0;
    load_clamped = load_val;
    up_c         = 1'b1;
    dn_c         = 1'b1;
    dig          = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig           = count_q[4*k +: 4];
      lim9[4*k +: 4] = 4'd9;
      if (up_c) up_val[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      if (dn_c) dn_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      up_c = up_c && (dig == 4'd9);
      dn_c = dn_c && (dig == 4'd0);
      if (load_val[4*k +: 4] > 4'd9) load_clamped[4*k +: 4] = 4'd9;
    end
    all9 = up_c;
    all0 = dn_c;
  end

  assign wrap_hit = dir ? all0 : all9;
  assign stepped  = dir ? dn_val : up_val;
  // Saturating counter holds at the limit instead of rolling over.
  assign sat_val  = wrap_hit ? count_q : stepped;

  always_comb begin
    presc_d  = presc_q;
    count_d  = count_q;
    lap_d    = lap_q;
    frozen_d = frozen_q;
    ovf_d    = ovf_q;
    if (clr) begin
      presc_d  = '0;
      count_d  = '0;
      lap_d    = '0;
      frozen_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      // Lap captures the count as presented this cycle, i.e. the pre-step value.
      if (lap) begin
        if (!frozen_q) begin
          lap_d    = count_q;
          frozen_d = 1'b1;
        end else begin
          frozen_d = 1'b0;
        end
      end
      if (load) begin
        count_d = load_clamped;
        presc_d = '0;
        ovf_d   = 1'b0;
      end else if (go && !stopped) begin
        presc_d = last ? '0 : presc_q + PW'(1);
        if (last) begin
          if (WRAP) begin
            count_d = stepped;
            if (wrap_hit) ovf_d = 1'b1;
          end else begin
            count_d = sat_val;
            // Flag as soon as the limit is reached so counting stops there.
            if (sat_val == (dir ? '0 : lim9)) ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      count_q  <= '0;
      lap_q    <= '0;
      frozen_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      lap_q    <= lap_d;
      frozen_q <= frozen_d;
      ovf_q    <= ovf_d;
    end
  end

  // Display mux is driven only by registers, so lap has no combinational path to disp.
  assign count  = count_q;
  assign disp   = frozen_q ? lap_q : count_q;
  assign frozen = frozen_q;
  assign ovf    = ovf_q;
  assign tick   = step;

endmodule
